// File: rtl/hwag_spi_pkg.sv
// Shared types and constants for the SPI transmit data-frame builder.
// Frame layout: [STAT8][ADDR8][DATA32 MSB first][CRC8], then FILL_BYTE forever.
package hwag_spi_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DRAIN} state_e;

  localparam int         FRAME_BYTES = 7;
  localparam logic [7:0] CRC8_POLY   = 8'h07;
  localparam logic [7:0] FILL_BYTE   = 8'hFF;

  // STAT8 = {valid, underrun, user[5:0]}
  localparam int STAT_VALID_BIT    = 7;
  localparam int STAT_UNDERRUN_BIT = 6;
  localparam int STAT_USER_W       = 6;

  typedef struct packed {
    logic [7:0]             addr;
    logic [31:0]            data;
    logic [STAT_USER_W-1:0] stat;
    logic                   valid;
  } pend_t;

  typedef struct packed {
    logic [7:0]  stat8;
    logic [7:0]  addr;
    logic [31:0] data;
  } act_t;

  function automatic logic [7:0] mk_stat8(input logic valid, input logic underrun,
                                          input logic [STAT_USER_W-1:0] user);
    return {valid, underrun, user};
  endfunction

  // Byte driven at a given frame index; index 7 is the drain filler.
  function automatic logic [7:0] frame_byte(input logic [2:0] idx, input act_t a,
                                            input logic [7:0] crc);
    case (idx)
      3'd0:    return a.stat8;
      3'd1:    return a.addr;
      3'd2:    return a.data[31:24];
      3'd3:    return a.data[23:16];
      3'd4:    return a.data[15:8];
      3'd5:    return a.data[7:0];
      3'd6:    return crc;
      default: return FILL_BYTE;
    endcase
  endfunction

endpackage

// File: rtl/hwag_spi_tx_data_frame_if.sv
// Handshake/bus bundle between the frame builder, its loader and spi_slave.
interface hwag_spi_tx_data_frame_if;
  logic        spi_ss;
  logic        spi_tx;
  logic        ld;
  logic [7:0]  ld_addr;
  logic [31:0] ld_data;
  logic [5:0]  ld_stat;
  logic [7:0]  bus_out;
  logic        busy;
  logic        frame_done;
  logic        frame_abort;

  modport slave (
    input  spi_ss, spi_tx, ld, ld_addr, ld_data, ld_stat,
    output bus_out, busy, frame_done, frame_abort
  );

  modport master (
    output spi_ss, spi_tx, ld, ld_addr, ld_data, ld_stat,
    input  bus_out, busy, frame_done, frame_abort
  );
endinterface

// File: rtl/hwag_spi_tx_data_frame_crc8.sv
// One-byte CRC8 step: poly 0x07, MSB first, no reflection, no final XOR.
module crc8_byte
  import hwag_spi_pkg::*;
(
  input  logic [7:0] crc_in,
  input  logic [7:0] byte_in,
  output logic [7:0] crc_out
);
  logic [7:0] c;

  // Shift eight bits of the byte through the LFSR.
  always_comb begin
    c = crc_in ^ byte_in;
    for (int i = 0; i < 8; i++)
      c = c[7] ? ({c[6:0], 1'b0} ^ CRC8_POLY) : {c[6:0], 1'b0};
    crc_out = c;
  end
endmodule

// File: rtl/hwag_spi_tx_data_frame.sv
// SPI transmit frame builder: serves STAT/ADDR/DATA/CRC bytes to spi_slave.
// Optional macro HWAG_SPI_TX_CRC_EN builds the CRC8 generator; without it
// byte 6 is 0x00.
module hwag_spi_tx_data_frame
  import hwag_spi_pkg::*;
(
  input  logic                      clk,
  input  logic                      nrst,
  hwag_spi_tx_data_frame_if.slave   bus
);
  state_e     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  pend_t      pend_q, pend_d;
  act_t       act_q, act_d;
  logic       underrun_q, underrun_d;
  logic       ss_prev_q, ss_prev_d;
  logic       done_q, done_d;
  logic       abort_q, abort_d;

  logic       ss_fall, ss_rise, start, advance;
  logic [2:0] idx_nxt;
  logic [7:0] pend_stat8, crc_tx;

  assign ss_fall    = ss_prev_q & ~bus.spi_ss;
  assign ss_rise    = ~ss_prev_q & bus.spi_ss;
  assign start      = (state_q == IDLE) & ss_fall;
  // A tx coinciding with ss rise belongs to the end-of-frame path.
  assign advance    = (state_q == SHIFT) & ~ss_rise & bus.spi_tx;
  assign idx_nxt    = idx_q + 3'd1;
  assign pend_stat8 = mk_stat8(pend_q.valid, underrun_q, pend_q.stat);

`ifdef HWAG_SPI_TX_CRC_EN
  logic [7:0] crc_q, crc_d, crc_in, crc_byte, crc_nxt;

  // At start seed with STAT8; during SHIFT fold in the byte about to be driven.
  assign crc_in   = (state_q == IDLE) ? 8'h00 : crc_q;
  assign crc_byte = (state_q == IDLE) ? pend_stat8 : frame_byte(idx_nxt, act_q, 8'h00);

  crc8_byte u_crc (.crc_in(crc_in), .byte_in(crc_byte), .crc_out(crc_nxt));

  // CRC accumulates only over bytes 0..5.
  always_comb begin
    crc_d = crc_q;
    if (start || (advance && idx_nxt <= 3'd5)) crc_d = crc_nxt;
  end

  // CRC accumulator register.
  always_ff @(posedge clk) begin
    if (!nrst) crc_q <= 8'h00;
    else       crc_q <= crc_d;
  end

  assign crc_tx = crc_q;
`else
  assign crc_tx = 8'h00;
`endif

  // Next-state, pending buffer and end-of-frame pulses.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    pend_d     = pend_q;
    act_d      = act_q;
    underrun_d = underrun_q;
    ss_prev_d  = bus.spi_ss;
    done_d     = 1'b0;
    abort_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (ss_fall) begin
          act_d        = '{stat8: pend_stat8, addr: pend_q.addr, data: pend_q.data};
          pend_d.valid = 1'b0;
          underrun_d   = 1'b0;
          idx_d        = 3'd0;
          state_d      = SHIFT;
        end
      end
      SHIFT, DRAIN: begin
        if (ss_rise) begin
          state_d = IDLE;
          done_d  = (idx_q == 3'd7);
          abort_d = (idx_q != 3'd7);
        end else if (bus.spi_tx) begin
          if (state_q == DRAIN) begin
            underrun_d = 1'b1;
          end else begin
            idx_d = idx_nxt;
            if (idx_q == 3'(FRAME_BYTES - 1)) state_d = DRAIN;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // A load always lands in pending, last one wins; never touches the active frame.
    if (bus.ld) pend_d = '{addr: bus.ld_addr, data: bus.ld_data, stat: bus.ld_stat, valid: 1'b1};
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q    <= IDLE;
      idx_q      <= 3'd0;
      pend_q     <= '0;
      act_q      <= '0;
      underrun_q <= 1'b0;
      done_q     <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      pend_q     <= pend_d;
      act_q      <= act_d;
      underrun_q <= underrun_d;
      done_q     <= done_d;
      abort_q    <= abort_d;
    end
  end

  // Edge detector keeps tracking through reset so a reset mid-frame never fakes a start.
  always_ff @(posedge clk) ss_prev_q <= ss_prev_d;

  assign bus.bus_out     = (state_q == IDLE) ? pend_stat8 : frame_byte(idx_q, act_q, crc_tx);
  assign bus.busy        = (state_q != IDLE);
  assign bus.frame_done  = done_q;
  assign bus.frame_abort = abort_q;

endmodule

// File: tb/tb_hwag_spi_tx_data_frame.sv
// Directed, table-driven bench for hwag_spi_tx_data_frame.
module tb_hwag_spi_tx_data_frame;
  logic clk = 1'b0;
  logic nrst;
  int   n_pass = 0;
  int   n_tot  = 0;

  hwag_spi_tx_data_frame_if bif();

  hwag_spi_tx_data_frame dut (.clk(clk), .nrst(nrst), .bus(bif));

  always #5 clk = ~clk;

  typedef struct {
    logic            do_ld;     // ld pulse before the frame
    logic            ld_start;  // ld in the same cycle as ss fall
    logic [7:0]      addr;
    logic [31:0]     data;
    logic [5:0]      stat;
    int              n_tx;
    logic [9:0][7:0] exp;       // expected bytes 0..9
    logic            exp_done;
    logic [7:0]      exp_idle;  // pending STAT8 shown after the frame
  } vec_t;

  vec_t vecs[8];

  function automatic logic [7:0] crc_ref(input logic [7:0] c, input logic [7:0] b);
    logic [7:0] r = c ^ b;
    for (int i = 0; i < 8; i++) r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    return r;
  endfunction

  function automatic logic [9:0][7:0] mk(input logic [7:0] b0, b1, b2, b3, b4, b5);
    logic [9:0][7:0] r;
    logic [7:0] c = 8'h00;
    r[0] = b0; r[1] = b1; r[2] = b2; r[3] = b3; r[4] = b4; r[5] = b5;
`ifdef HWAG_SPI_TX_CRC_EN
    for (int i = 0; i < 6; i++) c = crc_ref(c, r[i]);
`endif
    r[6] = c; r[7] = 8'hFF; r[8] = 8'hFF; r[9] = 8'hFF;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic load(input logic [7:0] a, input logic [31:0] d, input logic [5:0] s);
    bif.ld_addr = a; bif.ld_data = d; bif.ld_stat = s;
  endtask

  task automatic run_vec(input int i, input vec_t v);
    if (v.do_ld) begin
      bif.ld = 1'b1; load(v.addr, v.data, v.stat); cyc(); bif.ld = 1'b0;
    end
    bif.spi_ss = 1'b0;
    if (v.ld_start) begin bif.ld = 1'b1; load(v.addr, v.data, v.stat); end
    cyc();
    bif.ld = 1'b0;
    chk($sformatf("v%0d_byte0", i), 32'(bif.bus_out), 32'(v.exp[0]));
    chk($sformatf("v%0d_busy", i), 32'(bif.busy), 32'd1);
    for (int k = 1; k <= v.n_tx; k++) begin
      bif.spi_tx = 1'b1; cyc(); bif.spi_tx = 1'b0;
      chk($sformatf("v%0d_byte%0d", i, k), 32'(bif.bus_out), 32'(v.exp[k]));
    end
    bif.spi_ss = 1'b1; cyc();
    chk($sformatf("v%0d_done", i), 32'(bif.frame_done), 32'(v.exp_done));
    chk($sformatf("v%0d_abort", i), 32'(bif.frame_abort), 32'(!v.exp_done));
    chk($sformatf("v%0d_busy_end", i), 32'(bif.busy), 32'd0);
    chk($sformatf("v%0d_idle_stat", i), 32'(bif.bus_out), 32'(v.exp_idle));
    cyc();
    chk($sformatf("v%0d_pulse_clr", i), 32'({bif.frame_done, bif.frame_abort}), 32'd0);
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b0, 8'h01, 32'h12345678, 6'h05, 7,
                mk(8'h85, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78), 1'b1, 8'h05};
    vecs[1] = '{1'b0, 1'b0, 8'h00, 32'h0, 6'h00, 7,
                mk(8'h05, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78), 1'b1, 8'h05};
    vecs[2] = '{1'b1, 1'b0, 8'h22, 32'hCAFEF00D, 6'h3F, 9,
                mk(8'hBF, 8'h22, 8'hCA, 8'hFE, 8'hF0, 8'h0D), 1'b1, 8'h7F};
    vecs[3] = '{1'b0, 1'b0, 8'h00, 32'h0, 6'h00, 7,
                mk(8'h7F, 8'h22, 8'hCA, 8'hFE, 8'hF0, 8'h0D), 1'b1, 8'h3F};
    vecs[4] = '{1'b0, 1'b0, 8'h00, 32'h0, 6'h00, 7,
                mk(8'h3F, 8'h22, 8'hCA, 8'hFE, 8'hF0, 8'h0D), 1'b1, 8'h3F};
    vecs[5] = '{1'b1, 1'b0, 8'h33, 32'h01020304, 6'h0A, 3,
                mk(8'h8A, 8'h33, 8'h01, 8'h02, 8'h03, 8'h04), 1'b0, 8'h0A};
    vecs[6] = '{1'b0, 1'b1, 8'h44, 32'hAABBCCDD, 6'h11, 7,
                mk(8'h0A, 8'h33, 8'h01, 8'h02, 8'h03, 8'h04), 1'b1, 8'h91};
    vecs[7] = '{1'b0, 1'b0, 8'h00, 32'h0, 6'h00, 7,
                mk(8'h91, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD), 1'b1, 8'h11};

    nrst = 1'b0; bif.spi_ss = 1'b1; bif.spi_tx = 1'b0; bif.ld = 1'b0; load(8'h0, 32'h0, 6'h0);
    cyc(); cyc();
    nrst = 1'b1; cyc();
    chk("rst_bus_out", 32'(bif.bus_out), 32'h00);
    chk("rst_busy", 32'(bif.busy), 32'd0);
    chk("rst_done", 32'(bif.frame_done), 32'd0);
    chk("rst_abort", 32'(bif.frame_abort), 32'd0);

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // spi_tx in IDLE is ignored
    bif.spi_tx = 1'b1; cyc(); bif.spi_tx = 1'b0; cyc();
    chk("idle_tx_busy", 32'(bif.busy), 32'd0);
    chk("idle_tx_bus", 32'(bif.bus_out), 32'h11);

    // Reset while byte 3 is on the bus drops the frame silently
    bif.spi_ss = 1'b0; cyc();
    for (int k = 0; k < 3; k++) begin bif.spi_tx = 1'b1; cyc(); bif.spi_tx = 1'b0; end
    chk("mid_byte3", 32'(bif.bus_out), 32'hBB);
    nrst = 1'b0; cyc();
    chk("mid_rst_bus", 32'(bif.bus_out), 32'h00);
    chk("mid_rst_busy", 32'(bif.busy), 32'd0);
    chk("mid_rst_pulse", 32'({bif.frame_done, bif.frame_abort}), 32'd0);
    nrst = 1'b1; bif.spi_ss = 1'b1; cyc();
    chk("post_rst_pulse0", 32'({bif.frame_done, bif.frame_abort}), 32'd0);
    cyc();
    chk("post_rst_pulse1", 32'({bif.frame_done, bif.frame_abort}), 32'd0);
    chk("post_rst_bus", 32'(bif.bus_out), 32'h00);

    // ss rise coinciding with the 7th spi_tx: tx not counted, frame aborts
    bif.spi_ss = 1'b0; cyc();
    chk("coin_byte0", 32'(bif.bus_out), 32'h00);
    for (int k = 0; k < 6; k++) begin bif.spi_tx = 1'b1; cyc(); bif.spi_tx = 1'b0; end
    chk("coin_busy", 32'(bif.busy), 32'd1);
    bif.spi_ss = 1'b1; bif.spi_tx = 1'b1; cyc(); bif.spi_tx = 1'b0;
    chk("coin_abort", 32'(bif.frame_abort), 32'd1);
    chk("coin_done", 32'(bif.frame_done), 32'd0);
    chk("coin_underrun", 32'(bif.bus_out), 32'h00);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
